// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART word bridge.
//   BYTE_W     : width of one UART byte.
//   tx_state_e : TX serialiser FSM states.
//   byte_lane  : maps the n-th byte on the wire to its lane inside a word.
package uart_bridge_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        TxIdle,
        TxLoad,
        TxStart,
        TxWaitHi,
        TxWaitLo
    } tx_state_e;

    // Wire order index -> byte lane; lane k occupies word[8k+7:8k].
    function automatic int unsigned byte_lane(input int unsigned idx,
                                              input int unsigned nbytes,
                                              input bit          msb_first);
        return msb_first ? (nbytes - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with registered storage.
//   i_Clk, i_Rst_n : clock, async active-low reset
//   i_flush        : synchronous empty (wins over push/pop)
//   i_push, i_wdata: write request and data
//   i_pop          : read request (ignored when empty)
//   o_rdata        : head entry
//   o_full/o_empty : occupancy flags
//   o_count        : entries stored
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_pop, do_push;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_count = CNT_W'(wr_ptr_q - rd_ptr_q);
    assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_word_bridge.sv
// Bridge between a byte-wide UART core and a word-wide consumer/producer.
//   RX: i_rx_data/i_rx_valid bytes are packed into words and buffered; the
//       head is offered on o_rx_word/o_rx_word_valid/i_rx_word_ready.
//       o_rx_count gives occupancy, o_rx_overflow is sticky until i_flush.
//   TX: i_tx_word/i_tx_word_valid/o_tx_word_ready accepts a word which is
//       sent byte by byte through o_tx_byte/o_tx_start/i_tx_busy.
//       o_tx_active is high while a word is in flight.
module uart_word_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned DEPTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned RX_TIMEOUT = 50000,
    parameter int unsigned BUSY_WAIT  = 4
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_n,
    input  logic                         i_flush,
    input  logic [7:0]                   i_rx_data,
    input  logic                         i_rx_valid,
    output logic [8*WORD_BYTES-1:0]      o_rx_word,
    output logic                         o_rx_word_valid,
    input  logic                         i_rx_word_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_rx_count,
    output logic                         o_rx_overflow,
    input  logic [8*WORD_BYTES-1:0]      i_tx_word,
    input  logic                         i_tx_word_valid,
    output logic                         o_tx_word_ready,
    output logic [7:0]                   o_tx_byte,
    output logic                         o_tx_start,
    input  logic                         i_tx_busy,
    output logic                         o_tx_active
);

    localparam int unsigned W     = BYTE_W * WORD_BYTES;
    localparam int unsigned IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    // ---------------- RX assembly ----------------
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     asm_q, asm_d, asm_new;
    logic [31:0]      idle_q, idle_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, fifo_full, fifo_empty;

    assign pop = o_rx_word_valid && i_rx_word_ready;

    always_comb begin
        asm_new = asm_q;
        for (int unsigned k = 0; k < WORD_BYTES; k++) begin
            if (k == byte_lane(32'(idx_q), WORD_BYTES, MSB_FIRST)) begin
                asm_new[k*BYTE_W +: BYTE_W] = i_rx_data;
            end
        end
    end

    always_comb begin
        idx_d  = idx_q;
        asm_d  = asm_q;
        idle_d = idle_q;
        ovf_d  = ovf_q;
        push   = 1'b0;
        if (i_flush) begin
            idx_d  = '0;
            asm_d  = '0;
            idle_d = '0;
            ovf_d  = 1'b0;
        end else if (i_rx_valid) begin
            idle_d = '0;
            if (idx_q == LAST_IDX) begin
                push  = 1'b1;
                idx_d = '0;
                asm_d = '0;
                if (fifo_full && !pop) begin
                    ovf_d = 1'b1;
                end
            end else begin
                idx_d = idx_q + IDX_W'(1);
                asm_d = asm_new;
            end
        end else if (idx_q != '0 && RX_TIMEOUT != 0) begin
            // Partial word went stale: drop it silently.
            if (idle_q + 32'd1 >= 32'(RX_TIMEOUT)) begin
                idx_d  = '0;
                asm_d  = '0;
                idle_d = '0;
            end else begin
                idle_d = idle_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            idx_q  <= '0;
            asm_q  <= '0;
            idle_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            asm_q  <= asm_d;
            idle_q <= idle_d;
            ovf_q  <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH),
        .CNT_W ($clog2(DEPTH + 1))
    ) u_rx_fifo (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_flush (i_flush),
        .i_push  (push),
        .i_wdata (asm_new),
        .i_pop   (pop),
        .o_rdata (o_rx_word),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (o_rx_count)
    );

    assign o_rx_word_valid = !fifo_empty;
    assign o_rx_overflow   = ovf_q;

    // ---------------- TX serialiser ----------------
    tx_state_e        state_q, state_d;
    logic [W-1:0]     word_q;
    logic [IDX_W-1:0] cnt_q;
    logic [31:0]      wt_q;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= TxIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TxIdle:   if (i_tx_word_valid) state_d = TxLoad;
            TxLoad:   if (!i_tx_busy) state_d = TxStart;
            TxStart:  state_d = TxWaitHi;
            // Give up on busy after BUSY_WAIT cycles so a silent UART cannot hang us.
            TxWaitHi: if (i_tx_busy || (wt_q + 32'd1 >= 32'(BUSY_WAIT))) state_d = TxWaitLo;
            TxWaitLo: if (!i_tx_busy) state_d = (cnt_q == LAST_IDX) ? TxIdle : TxLoad;
            default:  state_d = TxIdle;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
            wt_q   <= '0;
        end else begin
            unique case (state_q)
                TxIdle: if (i_tx_word_valid) begin
                    word_q <= i_tx_word;
                    cnt_q  <= '0;
                end
                TxStart:  wt_q <= '0;
                TxWaitHi: if (!i_tx_busy) wt_q <= wt_q + 32'd1;
                TxWaitLo: if (!i_tx_busy) cnt_q <= cnt_q + IDX_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        o_tx_word_ready = (state_q == TxIdle);
        o_tx_active     = (state_q != TxIdle);
        o_tx_start      = (state_q == TxStart);
        o_tx_byte       = '0;
        if (state_q != TxIdle) begin
            for (int unsigned k = 0; k < WORD_BYTES; k++) begin
                if (k == byte_lane(32'(cnt_q), WORD_BYTES, MSB_FIRST)) begin
                    o_tx_byte = word_q[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed testbench for uart_word_bridge. Instance a: MSB_FIRST=1 with a
// 100-cycle RX timeout; instance b: MSB_FIRST=0 with the timeout disabled.
module tb_uart_word_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] tx_word;
    logic        tx_valid;
    logic        tx_busy;

    logic [31:0] a_rx_word, b_rx_word;
    logic        a_valid, b_valid;
    logic [3:0]  a_count, b_count;
    logic        a_ovf, b_ovf;
    logic        a_tx_ready, b_tx_ready;
    logic [7:0]  a_tx_byte, b_tx_byte;
    logic        a_tx_start, b_tx_start;
    logic        a_tx_active, b_tx_active;

    int errors = 0;
    int checks = 0;

    // UART transmitter model
    logic        uart_en = 1'b1;
    int          busy_cnt = 0;
    int          start_cnt = 0;
    int          falls = 0;
    int          cyc = 0;
    logic [7:0]  tx_log [16];
    int          start_cyc [16];

    always #5 clk = ~clk;

    uart_word_bridge #(
        .WORD_BYTES (4), .DEPTH (8), .MSB_FIRST (1'b1), .RX_TIMEOUT (100), .BUSY_WAIT (4)
    ) dut_a (
        .i_Clk (clk), .i_Rst_n (rst_n), .i_flush (flush),
        .i_rx_data (rx_data), .i_rx_valid (rx_valid),
        .o_rx_word (a_rx_word), .o_rx_word_valid (a_valid), .i_rx_word_ready (rx_ready),
        .o_rx_count (a_count), .o_rx_overflow (a_ovf),
        .i_tx_word (tx_word), .i_tx_word_valid (tx_valid), .o_tx_word_ready (a_tx_ready),
        .o_tx_byte (a_tx_byte), .o_tx_start (a_tx_start), .i_tx_busy (tx_busy),
        .o_tx_active (a_tx_active)
    );

    uart_word_bridge #(
        .WORD_BYTES (4), .DEPTH (8), .MSB_FIRST (1'b0), .RX_TIMEOUT (0), .BUSY_WAIT (4)
    ) dut_b (
        .i_Clk (clk), .i_Rst_n (rst_n), .i_flush (flush),
        .i_rx_data (rx_data), .i_rx_valid (rx_valid),
        .o_rx_word (b_rx_word), .o_rx_word_valid (b_valid), .i_rx_word_ready (rx_ready),
        .o_rx_count (b_count), .o_rx_overflow (b_ovf),
        .i_tx_word (tx_word), .i_tx_word_valid (tx_valid), .o_tx_word_ready (b_tx_ready),
        .o_tx_byte (b_tx_byte), .o_tx_start (b_tx_start), .i_tx_busy (tx_busy),
        .o_tx_active (b_tx_active)
    );

    assign tx_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            busy_cnt <= 0;
        end else begin
            if (a_tx_start) begin
                if (start_cnt < 16) begin
                    tx_log[start_cnt]    <= a_tx_byte;
                    start_cyc[start_cnt] <= cyc;
                end
                start_cnt <= start_cnt + 1;
            end
            if (a_tx_start && uart_en) begin
                busy_cnt <= 20;
            end else if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) falls <= falls + 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mkword(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'h10 + b, 8'h20 + b, 8'h30 + b, 8'h40 + b};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pop_one();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_ready = 1'b0;
        tx_word = '0; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a_valid); end
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", a_count); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
        checks++; if (a_rx_word !== 32'h0) begin errors++; $display("FAIL reset_word got %h want 0", a_rx_word); end
        checks++; if (a_tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", a_tx_ready); end
        checks++; if (a_tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", a_tx_start); end
        checks++; if (a_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h want 00", a_tx_byte); end
        checks++; if (a_tx_active !== 1'b0) begin errors++; $display("FAIL reset_tx_active got %b want 0", a_tx_active); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rx_order();
        send_word(32'h12345678);
        checks++; if (a_rx_word !== 32'h12345678) begin errors++; $display("FAIL msb_word got %h want 12345678", a_rx_word); end
        checks++; if (a_count !== 4'd1) begin errors++; $display("FAIL msb_count got %0d want 1", a_count); end
        checks++; if (b_rx_word !== 32'h78563412) begin errors++; $display("FAIL lsb_word got %h want 78563412", b_rx_word); end
        checks++; if (b_count !== 4'd1) begin errors++; $display("FAIL lsb_count got %0d want 1", b_count); end
        pop_one();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL pop_valid got %b want 0", a_valid); end
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL pop_count got %0d want 0", a_count); end
    endtask

    task automatic test_full_pop_push();
        flush_pulse();
        for (int i = 0; i < 8; i++) send_word(mkword(i));
        checks++; if (a_count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d want 8", a_count); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL fill_ovf got %b want 0", a_ovf); end
        send_byte(8'h18);
        send_byte(8'h28);
        send_byte(8'h38);
        @(negedge clk);
        rx_data = 8'h48; rx_valid = 1'b1; rx_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_ready = 1'b0;
        checks++; if (a_count !== 4'd8) begin errors++; $display("FAIL pushpop_count got %0d want 8", a_count); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL pushpop_ovf got %b want 0", a_ovf); end
        checks++; if (a_rx_word !== mkword(1)) begin errors++; $display("FAIL pushpop_head got %h want %h", a_rx_word, mkword(1)); end
        for (int i = 0; i < 7; i++) pop_one();
        checks++; if (a_rx_word !== 32'h18283848) begin errors++; $display("FAIL tail_word got %h want 18283848", a_rx_word); end
        checks++; if (a_count !== 4'd1) begin errors++; $display("FAIL tail_count got %0d want 1", a_count); end
    endtask

    task automatic test_overflow();
        flush_pulse();
        for (int i = 0; i < 9; i++) send_word(mkword(i));
        checks++; if (a_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", a_count); end
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", a_ovf); end
        checks++; if (a_rx_word !== mkword(0)) begin errors++; $display("FAIL ovf_head got %h want %h", a_rx_word, mkword(0)); end
        flush_pulse();
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", a_count); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL flush_ovf got %b want 0", a_ovf); end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", a_valid); end
    endtask

    task automatic test_timeout();
        flush_pulse();
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (100) @(negedge clk);
        send_word(32'hAABBCCDD);
        checks++; if (a_count !== 4'd1) begin errors++; $display("FAIL to_count got %0d want 1", a_count); end
        checks++; if (a_rx_word !== 32'hAABBCCDD) begin errors++; $display("FAIL to_word got %h want aabbccdd", a_rx_word); end
        // No timeout in instance b: stale bytes stay in the word.
        checks++; if (b_rx_word !== 32'hBBAA0201) begin errors++; $display("FAIL noto_word got %h want bbaa0201", b_rx_word); end
        checks++; if (b_count !== 4'd1) begin errors++; $display("FAIL noto_count got %0d want 1", b_count); end
    endtask

    task automatic test_tx_busy();
        int s0, f0, fdone;
        logic done;
        logic [7:0] exp [4];
        exp[0] = 8'hDE; exp[1] = 8'hAD; exp[2] = 8'hBE; exp[3] = 8'hEF;
        uart_en = 1'b1;
        s0 = start_cnt; f0 = falls; done = 1'b0; fdone = -1;
        @(negedge clk);
        tx_word = 32'hDEADBEEF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk); #1;
            done = a_tx_ready;
            if (done) fdone = falls - f0;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL tx_done got %b want 1", done); end
        checks++; if (fdone !== 4) begin errors++; $display("FAIL tx_ready_after_falls got %0d want 4", fdone); end
        checks++; if (start_cnt - s0 !== 4) begin errors++; $display("FAIL tx_starts got %0d want 4", start_cnt - s0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_log[s0+i] !== exp[i]) begin
                errors++; $display("FAIL tx_byte%0d got %h want %h", i, tx_log[s0+i], exp[i]);
            end
        end
    endtask

    task automatic test_tx_no_busy();
        int s0;
        logic done;
        uart_en = 1'b0;
        s0 = start_cnt; done = 1'b0;
        @(negedge clk);
        tx_word = 32'h01020304; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk); #1;
            done = a_tx_ready;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL nb_done got %b want 1", done); end
        checks++; if (start_cnt - s0 !== 4) begin errors++; $display("FAIL nb_starts got %0d want 4", start_cnt - s0); end
        checks++; if (tx_log[s0+3] !== 8'h04) begin errors++; $display("FAIL nb_last_byte got %h want 04", tx_log[s0+3]); end
        // START, 4 x WAIT_HI, WAIT_LO, LOAD between consecutive strobes.
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (start_cyc[s0+i+1] - start_cyc[s0+i] !== 7) begin
                errors++; $display("FAIL nb_spacing%0d got %0d want 7", i, start_cyc[s0+i+1] - start_cyc[s0+i]);
            end
        end
    endtask

    task automatic test_reset_mid_tx();
        int s0;
        logic seen;
        uart_en = 1'b1;
        s0 = start_cnt; seen = 1'b0;
        @(negedge clk);
        tx_word = 32'hCAFEF00D; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            seen = (start_cnt != s0);
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rm_first_start got %b want 1", seen); end
        repeat (3) @(negedge clk);
        checks++; if (a_tx_active !== 1'b1) begin errors++; $display("FAIL rm_active_before got %b want 1", a_tx_active); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_tx_active !== 1'b0) begin errors++; $display("FAIL rm_active got %b want 0", a_tx_active); end
        checks++; if (a_tx_start !== 1'b0) begin errors++; $display("FAIL rm_start got %b want 0", a_tx_start); end
        checks++; if (a_tx_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", a_tx_ready); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL rm_no_more_starts got %0d want 1", start_cnt - s0); end
    endtask

    initial begin
        test_reset();
        test_rx_order();
        test_full_pop_push();
        test_overflow();
        test_timeout();
        test_tx_busy();
        test_tx_no_busy();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_word_bridge.md
Name: uart_word_bridge

Overview:
- Parametrised bridge between the byte-wide UART core and a word-wide consumer/producer, such as the RISC-V core.
- RX path: packs UART bytes into WORD_BYTES-byte words and buffers them in a DEPTH-word FIFO with a valid/ready output.
- TX path: accepts a word on valid/ready and serialises it byte by byte into the UART transmitter using its start/busy handshake.
- Adds over the prior transmitter: configurable width, depth and byte order; inter-byte resync timeout; sticky overflow; flush.

Parameters:
- WORD_BYTES, 4: bytes per word; word width W = 8*WORD_BYTES, legal 1..8.
- DEPTH, 8: RX FIFO depth in words; power of two, at least 2.
- MSB_FIRST, 1: 1 means the first byte on the wire is word[W-1:W-8]; 0 means the first byte is word[7:0]. Applies to both RX and TX.
- RX_TIMEOUT, 50000: idle cycles after which a partial RX word is discarded; 0 disables the timeout.
- BUSY_WAIT, 4: maximum cycles to wait for i_tx_busy to rise after o_tx_start.

Ports:
- i_Clk, in, 1: system clock.
- i_Rst_n, in, 1: asynchronous active-low reset.
- i_flush, in, 1: synchronous clear of the RX side.
- i_rx_data, in, 8: received byte from the UART.
- i_rx_valid, in, 1: one-cycle strobe qualifying i_rx_data.
- o_rx_word, out, W: FIFO head word.
- o_rx_word_valid, out, 1: FIFO not empty.
- i_rx_word_ready, in, 1: consumer pops the head on valid&&ready.
- o_rx_count, out, $clog2(DEPTH+1): words currently stored.
- o_rx_overflow, out, 1: sticky flag, a completed word was dropped.
- i_tx_word, in, W: word to transmit.
- i_tx_word_valid, in, 1: TX request.
- o_tx_word_ready, out, 1: high only in TX IDLE.
- o_tx_byte, out, 8: byte to the UART transmitter.
- o_tx_start, out, 1: one-cycle send strobe.
- i_tx_busy, in, 1: UART transmitter busy.
- o_tx_active, out, 1: TX FSM not in IDLE.

Behaviour:
- Reset values:
  - FIFO empty; byte index 0; idle counter 0.
  - o_rx_word_valid=0, o_rx_count=0, o_rx_overflow=0, o_rx_word=0.
  - TX FSM in IDLE: o_tx_word_ready=1, o_tx_start=0, o_tx_byte=0, o_tx_active=0.
- RX assembly:
  - Each i_rx_valid writes a byte into the shift/assembly register at the position set by MSB_FIRST, then increments the byte index.
  - On the WORD_BYTES-th byte the word is pushed in the same cycle. It appears at o_rx_word_valid on the next edge when the FIFO was empty. Index wraps to 0.
- RX timeout:
  - The idle counter counts cycles while index≠0 and i_rx_valid=0.
  - When it reaches RX_TIMEOUT, the index and assembly register clear. No push, no flag.
  - A new byte resets the counter.
- RX FIFO:
  - Circular buffer with pointers of width log2(DEPTH)+1.
  - Pop occurs on o_rx_word_valid && i_rx_word_ready.
  - Push while full drops the word and sets o_rx_overflow.
  - Push and pop in the same cycle while full: pop frees a slot and the push is accepted, no overflow.
  - Push and pop in the same cycle while empty: not possible; push is visible next cycle.
  - o_rx_word is the registered head, valid whenever o_rx_word_valid=1.
- i_flush: in the next cycle the FIFO is empty, index=0, idle counter=0 and overflow=0. i_flush has priority over a simultaneous push or pop. It does not affect TX.
- TX FSM states:
  - IDLE: on i_tx_word_valid, latch the word, set byte counter to 0 and go to LOAD.
  - LOAD: drive o_tx_byte with the selected byte per MSB_FIRST; if i_tx_busy=0, go to START, otherwise hold.
  - START: o_tx_start=1 for exactly one cycle; go to WAIT_HI.
  - WAIT_HI: wait for i_tx_busy=1, or for BUSY_WAIT cycles to elapse; go to WAIT_LO.
  - WAIT_LO: when i_tx_busy=0, increment the byte counter; go to LOAD if bytes remain, else IDLE.
- TX latency: at least 3 cycles from acceptance to the first o_tx_start. o_tx_byte is stable from LOAD until the byte is done.
- Reset mid-operation: any state returns to IDLE asynchronously; the partial word is lost. No o_tx_start glitch is permitted during reset.

Decomposition:
- Package uart_bridge_pkg holds:
  - the TX state enum (IDLE, LOAD, START, WAIT_HI, WAIT_LO);
  - the byte-select helper function for MSB_FIRST ordering;
  - BYTE_W=8.
- One natural sub-module: sync_fifo (parametrised WIDTH and DEPTH, with full/empty/count), instantiated for the RX buffer.

Test Plan:
- Reset then bytes 0x12,0x34,0x56,0x78 with MSB_FIRST=1 -> o_rx_word=0x12345678, count=1. With MSB_FIRST=0 -> o_rx_word=0x78563412.
- DEPTH=8, push 9 words with ready=0 -> count=8, o_rx_overflow=1, head still the first word. Then i_flush -> count=0, overflow=0.
- Full FIFO, 4th byte arrives in the same cycle as a pop -> count stays 8, overflow stays 0, new word lands at the tail.
- RX_TIMEOUT=100: send 2 bytes, idle 100 cycles, then 0xAA,0xBB,0xCC,0xDD -> single word 0xAABBCCDD, no partial remnants.
- TX word 0xDEADBEEF with a UART model holding busy for 20 cycles per byte -> exactly 4 o_tx_start pulses with bytes DE,AD,BE,EF. o_tx_word_ready returns high only after the 4th busy falls.
- Busy never rises (BUSY_WAIT=4) -> FSM advances to the next byte after 4 cycles and does not hang. Async reset asserted in WAIT_LO -> IDLE, o_tx_start=0.
